// File: rtl/irq_ctrl_16.sv
// irq_ctrl_16 -- 16-source priority interrupt controller.
//
// Rising edges on irq[] latch sticky pending bits. Among pending sources
// not disabled by the mask register, the highest index is offered to the
// consumer. The consumer accepts it with ack and ends service with eoi.
// Only one interrupt is in flight at a time; there is no nesting.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   irq[15:0]   interrupt request lines, bit 15 highest priority
//   mask_we     load mask register from mask_wdata
//   mask_wdata  new mask value, 1 = source disabled
//   ack         consumer accepts the offered interrupt
//   eoi         consumer finished servicing the interrupt
//   irq_valid   an interrupt is being offered
//   irq_id      index of the offered / in-service source
//   busy        an interrupt is in service
//   pending     registered pending bits
module irq_ctrl_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] irq,
    input  logic        mask_we,
    input  logic [15:0] mask_wdata,
    input  logic        ack,
    input  logic        eoi,
    output logic        irq_valid,
    output logic [3:0]  irq_id,
    output logic        busy,
    output logic [15:0] pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] irq_d;
    logic [15:0] mask;
    logic [15:0] edge_vec;
    logic [15:0] eligible;
    logic [15:0] clr_vec;
    logic [3:0]  sel_id;
    logic        id_load;
    logic        ack_take;

    // Highest set index wins; an all-zero vector encodes to 0 but is never
    // loaded because IDLE only latches when eligible is non-zero.
    function automatic logic [3:0] prio_enc(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    assign edge_vec = irq & ~irq_d;
    assign eligible = pending & ~mask;
    assign sel_id   = prio_enc(eligible);
    assign clr_vec  = ack_take ? (16'h0001 << irq_id) : 16'h0000;

    assign irq_valid = (state == OFFER);
    assign busy      = (state == SERVICE);

    always_comb begin
        state_nxt = state;
        id_load   = 1'b0;
        ack_take  = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nxt = OFFER;
                    id_load   = 1'b1;
                end
            end
            OFFER: begin
                if (ack) begin
                    state_nxt = SERVICE;
                    ack_take  = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A fresh edge on the source being acknowledged must survive the clear,
    // so the set term is applied after the clear term.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_d   <= 16'h0000;
            pending <= 16'h0000;
            mask    <= 16'h0000;
            irq_id  <= 4'd0;
        end else begin
            irq_d   <= irq;
            pending <= (pending & ~clr_vec) | edge_vec;
            if (mask_we) mask <= mask_wdata;
            if (id_load) irq_id <= sel_id;
        end
    end

endmodule

// File: tb/tb_irq_ctrl_16.sv
module tb_irq_ctrl_16;

    logic        clk;
    logic        rst;
    logic [15:0] irq;
    logic        mask_we;
    logic [15:0] mask_wdata;
    logic        ack;
    logic        eoi;
    logic        irq_valid;
    logic [3:0]  irq_id;
    logic        busy;
    logic [15:0] pending;

    int total = 0;
    int bad   = 0;

    irq_ctrl_16 dut (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack        (ack),
        .eoi        (eoi),
        .irq_valid  (irq_valid),
        .irq_id     (irq_id),
        .busy       (busy),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full observable state in one call.
    task automatic chk_all(input string tag, input logic v, input logic b,
                           input logic [3:0] id, input logic [15:0] p);
        chk({tag, ".valid"}, {15'd0, irq_valid}, {15'd0, v});
        chk({tag, ".busy"},  {15'd0, busy},      {15'd0, b});
        chk({tag, ".id"},    {12'd0, irq_id},    {12'd0, id});
        chk({tag, ".pend"},  pending,            p);
    endtask

    initial begin
        rst        = 1'b1;
        irq        = 16'h0000;
        mask_we    = 1'b0;
        mask_wdata = 16'h0000;
        ack        = 1'b0;
        eoi        = 1'b0;
        #1;
        chk_all("reset0", 1'b0, 1'b0, 4'd0, 16'h0000);
        tick();
        tick();
        chk_all("reset1", 1'b0, 1'b0, 4'd0, 16'h0000);
        rst = 1'b0;
        tick();
        chk_all("idle", 1'b0, 1'b0, 4'd0, 16'h0000);

        // Single source 5
        irq = 16'h0020;
        tick();
        irq = 16'h0000;
        chk_all("s5.pend", 1'b0, 1'b0, 4'd0, 16'h0020);
        tick();
        chk_all("s5.offer", 1'b1, 1'b0, 4'd5, 16'h0020);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_all("s5.serv", 1'b0, 1'b1, 4'd5, 16'h0000);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk_all("s5.done", 1'b0, 1'b0, 4'd5, 16'h0000);

        // Priority 12 over 3; eoi during OFFER ignored
        irq = 16'h1008;
        tick();
        irq = 16'h0000;
        chk("pr.pend", pending, 16'h1008);
        tick();
        chk_all("pr.offer12", 1'b1, 1'b0, 4'd12, 16'h1008);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk_all("pr.eoi_ign", 1'b1, 1'b0, 4'd12, 16'h1008);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_all("pr.serv12", 1'b0, 1'b1, 4'd12, 16'h0008);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_all("pr.ack_ign", 1'b0, 1'b1, 4'd12, 16'h0008);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk_all("pr.idle", 1'b0, 1'b0, 4'd12, 16'h0008);
        tick();
        chk_all("pr.offer3", 1'b1, 1'b0, 4'd3, 16'h0008);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk_all("pr.done", 1'b0, 1'b0, 4'd3, 16'h0000);

        // Stability: id 4 held while 15 arrives; level-held 4 not re-pended
        irq = 16'h0010;
        tick();
        tick();
        chk_all("st.offer4", 1'b1, 1'b0, 4'd4, 16'h0010);
        irq = 16'h8010;
        tick();
        chk_all("st.hold4", 1'b1, 1'b0, 4'd4, 16'h8010);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_all("st.serv4", 1'b0, 1'b1, 4'd4, 16'h8000);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk_all("st.idle", 1'b0, 1'b0, 4'd4, 16'h8000);
        tick();
        chk_all("st.offer15", 1'b1, 1'b0, 4'd15, 16'h8000);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        irq = 16'h0000;
        chk_all("st.done", 1'b0, 1'b0, 4'd15, 16'h0000);
        tick();

        // Mask source 8, then unmask
        mask_we    = 1'b1;
        mask_wdata = 16'h0100;
        tick();
        mask_we = 1'b0;
        irq     = 16'h0100;
        tick();
        irq = 16'h0000;
        chk_all("mk.pend", 1'b0, 1'b0, 4'd15, 16'h0100);
        tick();
        tick();
        chk_all("mk.masked", 1'b0, 1'b0, 4'd15, 16'h0100);
        mask_we    = 1'b1;
        mask_wdata = 16'h0000;
        tick();
        mask_we = 1'b0;
        chk_all("mk.load", 1'b0, 1'b0, 4'd15, 16'h0100);
        tick();
        chk_all("mk.offer8", 1'b1, 1'b0, 4'd8, 16'h0100);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk_all("mk.done", 1'b0, 1'b0, 4'd8, 16'h0000);

        // Collision: new edge on 7 together with ack of 7
        irq = 16'h0080;
        tick();
        irq = 16'h0000;
        tick();
        chk_all("co.offer7", 1'b1, 1'b0, 4'd7, 16'h0080);
        irq = 16'h0080;
        ack = 1'b1;
        tick();
        irq = 16'h0000;
        ack = 1'b0;
        chk_all("co.serv7", 1'b0, 1'b1, 4'd7, 16'h0080);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        chk_all("co.reoffer7", 1'b1, 1'b0, 4'd7, 16'h0080);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_all("co.serv7b", 1'b0, 1'b1, 4'd7, 16'h0000);

        // Reset mid-SERVICE with mask bit 2 set and irq[2] held high
        irq        = 16'h0004;
        mask_we    = 1'b1;
        mask_wdata = 16'h0004;
        tick();
        mask_we = 1'b0;
        chk_all("rs.before", 1'b0, 1'b1, 4'd7, 16'h0004);
        #3;
        rst = 1'b1;
        #1;
        chk_all("rs.async", 1'b0, 1'b0, 4'd0, 16'h0000);
        #2;
        rst = 1'b0;
        tick();
        chk_all("rs.edge2", 1'b0, 1'b0, 4'd0, 16'h0004);
        tick();
        chk_all("rs.offer2", 1'b1, 1'b0, 4'd2, 16'h0004);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        irq = 16'h0000;
        chk_all("rs.done", 1'b0, 1'b0, 4'd2, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl_16.md
IRQ_CTRL_16 -- requirements
Module: irq_ctrl_16

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port irq  input  16  interrupt request lines, index 15 highest priority.
REQ-004 SHALL have port mask_we  input  1  mask register write strobe.
REQ-005 SHALL have port mask_wdata  input  16  new mask value; bit=1 disables that source.
REQ-006 SHALL have port ack  input  1  consumer accepts offered interrupt.
REQ-007 SHALL have port eoi  input  1  end-of-interrupt from consumer.
REQ-008 SHALL have port irq_valid  output  1  an interrupt is being offered.
REQ-009 SHALL have port irq_id  output  4  encoded index of the offered or in-service source.
REQ-010 SHALL have port busy  output  1  an interrupt is in service.
REQ-011 SHALL have port pending  output  16  registered pending bits.
REQ-012 SHALL use one clock; reset is asynchronous and active-high, ports named clk and rst.

Function
REQ-013 SHALL register irq each cycle into irq_d; source i edge = irq[i] & ~irq_d[i].
REQ-014 SHALL set pending[i] on the clock edge where source i edge is detected, independent of mask and FSM state.
REQ-015 SHALL define eligible = pending & ~mask; selected id = highest set index of eligible (16-to-4 priority encode).
REQ-016 SHALL implement FSM states IDLE, OFFER, SERVICE.
REQ-017 IDLE: irq_valid=0, busy=0; if eligible != 0, latch selected id into irq_id and go to OFFER.
REQ-018 OFFER: irq_valid=1; irq_id held stable until ack, even if higher-priority sources become pending or the offered source is masked.
REQ-019 OFFER with ack=1: clear pending[irq_id], go to SERVICE; irq_valid=0 from next cycle.
REQ-020 SERVICE: busy=1, irq_valid=0, irq_id holds serviced id; eoi=1 returns to IDLE. No nesting/preemption.
REQ-021 SHALL ignore ack outside OFFER and eoi outside SERVICE.
REQ-022 Same-cycle new edge on source k and ack clearing pending[k]: set wins, pending[k]=1 afterwards.
REQ-023 mask_we=1 SHALL load mask on that edge; new mask affects selection from the following cycle.
REQ-024 Latency: edge sampled at clock edge n -> pending set after n -> OFFER entered and irq_valid=1 after edge n+1 (if IDLE).
REQ-025 After eoi at edge m, a still-eligible source SHALL be offered with irq_valid=1 after edge m+1.
REQ-026 Level-held irq SHALL NOT re-set pending after clearing; a new rising edge is required.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, pending=0, irq_d=0, mask=16'h0000, irq_valid=0, busy=0, irq_id=0.
REQ-028 rst asserted mid-OFFER or mid-SERVICE SHALL abandon the transaction; no ack/eoi needed afterwards.
REQ-029 irq lines already high when rst deasserts SHALL register as edges on the first clock (irq_d=0).

Verification
REQ-030 Single source: pulse irq[5] -> irq_valid=1, irq_id=5 two edges later; ack -> pending[5]=0, busy=1; eoi -> busy=0.
REQ-031 Priority: irq[3] and irq[12] rise same cycle -> id=12 offered; after ack+eoi, id=3 offered one edge after eoi.
REQ-032 Stability: offer id=4 pending, then irq[15] rises before ack -> irq_id stays 4 until ack; 15 offered after eoi.
REQ-033 Mask: write mask=16'h0100, pulse irq[8] -> no offer, pending[8]=1; write mask=0 -> id=8 offered.
REQ-034 Collision: during OFFER id=7, new edge on irq[7] same cycle as ack -> pending[7]=1, re-offered after eoi.
REQ-035 Reset mid-SERVICE: rst pulse while busy=1 -> all outputs 0, mask=0, pending=0 asynchronously.
